popcount_seq: RTL and testbench

Parametrised, sequential successor to the 3-input transistor-level one-counter. Counts the ones in a WIDTH-bit word, CHUNK bits per clock, using valid/ready handshakes on input and output. An optional saturating running total accumulates counts across words. Sits between a word source and a statistics consumer in the datapath.

---
 rtl/popcount_seq.sv | 141 ++++++++++++++
 tb/tb_popcount_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_seq.sv
// popcount_seq: counts the ones in a WIDTH-bit word CHUNK bits per clock,
// with valid/ready handshakes and an optional saturating running total.
`default_nettype none

module popcount_seq #(
    parameter int WIDTH      = 8,
    parameter int CHUNK      = 1,
    parameter int ACC_W      = 16,
    parameter int EARLY_EXIT = 0,
    localparam int CW        = $clog2(WIDTH + 1),
    localparam int STEPS     = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_acc,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic [ACC_W-1:0] acc_total,
    output logic             busy
);

    localparam int SW   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int SUMW = ((ACC_W > CW) ? ACC_W : CW) + 1;
    localparam logic [SUMW-1:0] ACC_MAX = SUMW'({ACC_W{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sh_q;
    logic [CW-1:0]      cnt_q;
    logic [SW-1:0]      step_q;
    logic               acc_flag_q;
    logic               out_valid_q;
    logic [CW-1:0]      out_count_q;
    logic [ACC_W-1:0]   acc_total_q;

    logic [WIDTH-1:0]   sh_d;
    logic [CW-1:0]      cnt_d;
    logic               last_step;
    logic [SUMW-1:0]    acc_sum;
    logic [ACC_W-1:0]   acc_total_d;

    function automatic logic [CW-1:0] chunk_ones(input logic [CHUNK-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < CHUNK; i++) begin
            r = r + CW'(v[i]);
        end
        return r;
    endfunction

    always_comb begin
        sh_d      = sh_q >> CHUNK;
        cnt_d     = cnt_q + chunk_ones(sh_q[CHUNK-1:0]);
        last_step = (step_q == SW'(STEPS - 1));
        // Nothing left to find once the unscanned bits are all zero.
        if (EARLY_EXIT != 0 && sh_d == '0) begin
            last_step = 1'b1;
        end
    end

    // One guard bit beyond the widest operand, so the sum can never wrap.
    always_comb begin
        acc_sum = SUMW'(acc_total_q) + SUMW'(cnt_d);
        if (acc_sum > ACC_MAX) begin
            acc_total_d = {ACC_W{1'b1}};
        end else begin
            acc_total_d = acc_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            step_q      <= '0;
            acc_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            acc_total_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sh_q       <= in_data;
                        cnt_q      <= '0;
                        step_q     <= '0;
                        acc_flag_q <= in_acc;
                        state_q    <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    sh_q   <= sh_d;
                    cnt_q  <= cnt_d;
                    step_q <= step_q + SW'(1);
                    if (last_step) begin
                        out_count_q <= cnt_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                        if (acc_flag_q) begin
                            acc_total_q <= acc_total_d;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
            // A coincident accumulate update is dropped in favour of clear.
            if (clear) begin
                acc_total_q <= '0;
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_COUNT) || (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign acc_total = acc_total_q;

endmodule

`default_nettype wire

// File: tb/tb_popcount_seq.sv
// tb_popcount_seq: three popcount_seq configurations checked against a
// transaction-level model every cycle, plus hand-computed directed checks.
`default_nettype none

module tb_popcount_seq;

    localparam int N = 3;
    localparam int CH[N]  = '{1, 2, 1};
    localparam int AWD[N] = '{16, 4, 16};
    localparam int EEX[N] = '{0, 0, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_acc = 1'b0;
    logic clear = 1'b0;
    logic out_ready = 1'b0;
    int   sel = 0;

    always #5 clk = ~clk;

    logic vld0, vld1, vld2;
    assign vld0 = in_valid && (sel == 0);
    assign vld1 = in_valid && (sel == 1);
    assign vld2 = in_valid && (sel == 2);

    logic ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
    logic [3:0] oc0, oc1, oc2;
    logic [15:0] at0, at2;
    logic [3:0] at1;

    popcount_seq #(.WIDTH(8), .CHUNK(1), .ACC_W(16), .EARLY_EXIT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(vld0), .in_ready(ir0), .in_data(in_data),
        .in_acc(in_acc), .clear(clear), .out_valid(ov0), .out_ready(out_ready),
        .out_count(oc0), .acc_total(at0), .busy(bz0));

    popcount_seq #(.WIDTH(8), .CHUNK(2), .ACC_W(4), .EARLY_EXIT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vld1), .in_ready(ir1), .in_data(in_data),
        .in_acc(in_acc), .clear(clear), .out_valid(ov1), .out_ready(out_ready),
        .out_count(oc1), .acc_total(at1), .busy(bz1));

    popcount_seq #(.WIDTH(8), .CHUNK(1), .ACC_W(16), .EARLY_EXIT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vld2), .in_ready(ir2), .in_data(in_data),
        .in_acc(in_acc), .clear(clear), .out_valid(ov2), .out_ready(out_ready),
        .out_count(oc2), .acc_total(at2), .busy(bz2));

    logic ov[N], ir[N], bz[N], vld[N];
    int   oc[N], at[N];
    always_comb begin
        ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
        ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
        bz[0] = bz0; bz[1] = bz1; bz[2] = bz2;
        vld[0] = vld0; vld[1] = vld1; vld[2] = vld2;
        oc[0] = int'(oc0); oc[1] = int'(oc1); oc[2] = int'(oc2);
        at[0] = int'(at0); at[1] = int'(at1); at[2] = int'(at2);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0=idle, 1=counting, 2=result held.
    int   m_phase[N], m_left[N], m_cnt[N], m_total[N];
    logic m_flag[N], m_valid[N];
    logic [7:0] m_word[N];

    function automatic int latency_of(input int k, input logic [7:0] d);
        int nb, l;
        if (EEX[k] == 0) return 8 / CH[k];
        nb = 0;
        for (int i = 0; i < 8; i++) if (d[i]) nb = i + 1;
        l = (nb + CH[k] - 1) / CH[k];
        return (l < 1) ? 1 : l;
    endfunction

    function automatic int sat_add(input int k, input int a, input int b);
        int mx;
        mx = (1 << AWD[k]) - 1;
        return (a + b > mx) ? mx : a + b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_phase[k] <= 0; m_left[k] <= 0; m_cnt[k] <= 0; m_total[k] <= 0;
                m_flag[k] <= 1'b0; m_valid[k] <= 1'b0; m_word[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                case (m_phase[k])
                    0: if (vld[k]) begin
                        m_phase[k] <= 1;
                        m_left[k]  <= latency_of(k, in_data);
                        m_word[k]  <= in_data;
                        m_flag[k]  <= in_acc;
                    end
                    1: if (m_left[k] == 1) begin
                        m_phase[k] <= 2;
                        m_valid[k] <= 1'b1;
                        m_cnt[k]   <= $countones(m_word[k]);
                        if (m_flag[k]) m_total[k] <= sat_add(k, m_total[k], $countones(m_word[k]));
                    end else begin
                        m_left[k] <= m_left[k] - 1;
                    end
                    default: if (out_ready) begin
                        m_phase[k] <= 0;
                        m_valid[k] <= 1'b0;
                    end
                endcase
                if (clear) m_total[k] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            chk($sformatf("u%0d out_valid", k), int'(ov[k]), int'(m_valid[k]));
            chk($sformatf("u%0d out_count", k), oc[k], m_cnt[k]);
            chk($sformatf("u%0d acc_total", k), at[k], m_total[k]);
            chk($sformatf("u%0d in_ready", k), int'(ir[k]), int'(m_phase[k] == 0));
            chk($sformatf("u%0d busy", k), int'(bz[k]), int'(m_phase[k] != 0));
        end
    end

    task automatic run_word(input int k, input logic [7:0] d, input logic a,
                            input int exp_cnt, input int exp_lat, input int exp_tot,
                            input int hold);
        int lat;
        @(negedge clk);
        sel = k; in_valid = 1'b1; in_data = d; in_acc = a;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'($urandom); in_acc = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!ov[k] && lat < 40);
        chk($sformatf("u%0d lat %02h", k, d), lat, exp_lat);
        chk($sformatf("u%0d cnt %02h", k, d), oc[k], exp_cnt);
        chk($sformatf("u%0d tot %02h", k, d), at[k], exp_tot);
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0]; in_data = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("u%0d held valid", k), int'(ov[k]), 1);
            chk($sformatf("u%0d held cnt", k), oc[k], exp_cnt);
            chk($sformatf("u%0d held in_ready", k), int'(ir[k]), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("u%0d drained valid", k), int'(ov[k]), 0);
        chk($sformatf("u%0d idle in_ready", k), int'(ir[k]), 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset u0 in_ready", int'(ir0), 1);
        chk("reset u0 out_count", int'(oc0), 0);
        rst_n = 1'b1;

        run_word(0, 8'hB5, 1'b1, 5, 8, 5, 0);
        run_word(0, 8'h0F, 1'b0, 4, 8, 5, 5);

        run_word(1, 8'hFF, 1'b0, 8, 4, 0, 0);
        run_word(1, 8'h00, 1'b0, 0, 4, 0, 0);
        run_word(1, 8'hFF, 1'b1, 8, 4, 8, 0);
        run_word(1, 8'hFF, 1'b1, 8, 4, 15, 0);
        run_word(1, 8'hFF, 1'b1, 8, 4, 15, 0);
        run_word(1, 8'hFF, 1'b0, 8, 4, 15, 0);

        run_word(2, 8'h03, 1'b0, 2, 2, 0, 0);
        run_word(2, 8'h00, 1'b0, 0, 1, 0, 0);
        run_word(2, 8'h80, 1'b1, 1, 8, 1, 0);
        run_word(2, 8'h24, 1'b1, 2, 6, 3, 0);

        // clear lands on the very edge the accumulate would happen
        @(negedge clk);
        sel = 0; in_valid = 1'b1; in_data = 8'hFF; in_acc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        chk("clear-edge valid", int'(ov0), 1);
        chk("clear-edge cnt", int'(oc0), 8);
        chk("clear-edge tot", int'(at0), 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        run_word(0, 8'h11, 1'b1, 2, 8, 2, 0);

        // asynchronous reset in the middle of a count
        @(negedge clk);
        sel = 0; in_valid = 1'b1; in_data = 8'hAA; in_acc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst valid", int'(ov0), 0);
        chk("async rst cnt", int'(oc0), 0);
        chk("async rst tot", int'(at0), 0);
        chk("async rst in_ready", int'(ir0), 1);
        chk("async rst busy", int'(bz0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post rst no valid", int'(ov0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
